axis_rr_arb_mux: RTL
====================

Name: axis_rr_arb_mux

Overview:
- Shares one AXI4-Stream output between S_COUNT input streams using packet-granular round-robin arbitration.
- The output always passes through an internal 2-entry skid buffer, so no combinational path exists from m_axis_tready to any s_axis_tready.
- Used in front of shared stream consumers (DMA write engines, shared register pipelines) where several producers contend for one channel.

Parameters:
- S_COUNT, 4, number of input streams (2..16).
- DATA_WIDTH, 8, tdata width per stream.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width per stream.
- USER_WIDTH, 1, tuser width per stream.
- ARB_LOCK, 1, 1 = grant held until the tlast beat; 0 = grant released after every beat.
- IDX_WIDTH, $clog2(S_COUNT), width of the source index.

Ports:
- aclk  in  1  clock.
- areset  in  1  async active-high reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed; stream i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed tkeep.
- s_axis_tvalid  in  S_COUNT  per-stream valid.
- s_axis_tready  out  S_COUNT  per-stream ready.
- s_axis_tlast  in  S_COUNT  per-stream last.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed tuser.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tid  out  IDX_WIDTH  index of the source of this beat.
- m_axis_tuser  out  USER_WIDTH  output user.
- grant_valid  out  1  arbiter currently holds a grant.
- grant_index  out  IDX_WIDTH  current or last granted source.

Behaviour:
- Reset: asynchronous, active-high. While areset is high, hold all of the following:
  - FSM in IDLE; s_axis_tready all 0.
  - m_axis_tvalid = 0; skid buffer empty.
  - grant_valid = 0; grant_index = S_COUNT-1, so the first post-reset search starts at stream 0.
  - All m_axis data fields = 0.
- Reset mid-packet: the packet is truncated, the buffered beats are discarded, and no partial output remains after reset.
- FSM state IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid is high, select the first asserted stream searching from (grant_index+1) mod S_COUNT upward, with wrap-around.
  - At the clock edge: register grant_index = selection, grant_valid = 1, go to GRANT.
  - If no stream is valid, remain in IDLE and leave grant_index unchanged.
- FSM state GRANT:
  - s_axis_tready[grant_index] = internal skid-buffer ready (registered); every other ready bit = 0.
  - A transfer occurs when tvalid & tready are both high on the granted stream. It captures data, keep, last, user and tid = grant_index.
  - Release condition: ARB_LOCK=1, a transfer with tlast=1; ARB_LOCK=0, any transfer.
  - On release: grant_valid = 0 and go to IDLE at the next edge. grant_index is retained as the round-robin pointer.
  - If the granted stream deasserts tvalid mid-packet, the grant is held and no other stream is served.
- Arbitration cost: one IDLE bubble cycle per grant. Maximum input throughput is therefore (L/(L+1)) beats/cycle for L-beat packets.
- Latency: first beat appears on m_axis two cycles after its tvalid rises with the arbiter idle (one cycle IDLE→GRANT, one cycle input→output register).
- Skid buffer: output register plus temp register.
  - Internal ready (next cycle) = m_axis_tready | (temp empty & (output empty | no incoming beat)).
  - No bubbles occur while m_axis_tready=1. No beat is lost or duplicated under arbitrary m_axis_tready toggling.
- Output ordering:
  - Beats of one packet are contiguous on the output when ARB_LOCK=1.
  - Output order equals acceptance order.
  - m_axis fields are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Boundary cases:
  - Simultaneous requests from all streams: served in order g+1, g+2, … with wrap.
  - A single requester is re-granted back-to-back, with one bubble cycle between grants.
  - S_COUNT=2 uses a 1-bit index.
  - tkeep and tuser pass through unmodified. No width conversion.

Test Plan:
- Reset, then stream 2 sends a 3-beat packet (data 0x11, 0x22, 0x33; last on 0x33) with m_axis_tready=1 → s_axis_tready[2] high for 3 cycles starting 1 cycle after tvalid. Output shows 0x11, 0x22, 0x33 with tid=2, tlast on beat 3, first beat 2 cycles after tvalid. grant_valid then falls.
- All 4 streams hold 2-beat packets continuously, ARB_LOCK=1 → output tid sequence 0,0,1,1,2,2,3,3,0,0… with no interleaving inside packets.
- Same traffic with ARB_LOCK=0 → tid sequence 0,1,2,3,0,1… (one beat per grant).
- Stream 1 mid-packet drops tvalid for 5 cycles while stream 3 is valid → no stream-3 beat appears before stream 1's tlast; stream 3 is granted next.
- Random m_axis_tready (50%), 1000 random packets from 4 streams → scoreboard per-tid packets match exactly. No loss or duplication; outputs stable during stalls.
- Assert areset for 1 cycle during beat 2 of a 4-beat packet → m_axis_tvalid=0 and all s_axis_tready=0 immediately. The next grant goes to stream 0 if it is valid.

Source files
------------

// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux: shares one AXI4-Stream output between S_COUNT inputs.
// Arbitration is round-robin at packet (or beat) granularity. The output is
// decoupled by a 2-entry skid buffer so m_axis_tready never reaches
// s_axis_tready combinationally.
module axis_rr_arb_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int ARB_LOCK   = 1,
  parameter int IDX_WIDTH  = $clog2(S_COUNT)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [IDX_WIDTH-1:0]          m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [IDX_WIDTH-1:0]          grant_index
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t state;

  logic [IDX_WIDTH-1:0]  next_index;
  logic                  any_valid;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic [USER_WIDTH-1:0] sel_user;

  logic                  xfer;
  logic                  int_ready_reg;
  logic                  int_ready_early;

  logic [DATA_WIDTH-1:0] temp_data;
  logic [KEEP_WIDTH-1:0] temp_keep;
  logic                  temp_valid;
  logic                  temp_last;
  logic [IDX_WIDTH-1:0]  temp_tid;
  logic [USER_WIDTH-1:0] temp_user;

  // Round-robin search: first valid stream starting just after the last grant.
  always_comb begin
    logic [IDX_WIDTH-1:0] cand;
    cand       = '0;
    next_index = grant_index;
    any_valid  = 1'b0;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = IDX_WIDTH'((int'(grant_index) + i) % S_COUNT);
      if (!any_valid && s_axis_tvalid[cand]) begin
        next_index = cand;
        any_valid  = 1'b1;
      end
    end
  end

  // Select the fields of the currently granted stream.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == IDX_WIDTH'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Only the granted stream sees the registered skid-buffer ready.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_axis_tready[i] = (state == GRANT) && (grant_index == IDX_WIDTH'(i)) && int_ready_reg;
    end
  end

  assign xfer = (state == GRANT) && sel_valid && int_ready_reg;

  // Next-cycle ready: accept if the sink drains or the buffer has room to spare.
  assign int_ready_early = m_axis_tready || (!temp_valid && (!m_axis_tvalid || !xfer));

  // Arbiter FSM: IDLE picks a requester, GRANT serves it until release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_index <= IDX_WIDTH'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_index <= next_index;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (xfer && (ARB_LOCK == 0 || sel_last)) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: output register plus temp register absorbing one beat on a stall.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      int_ready_reg <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
      temp_valid    <= 1'b0;
      temp_data     <= '0;
      temp_keep     <= '0;
      temp_last     <= 1'b0;
      temp_tid      <= '0;
      temp_user     <= '0;
    end else begin
      int_ready_reg <= int_ready_early;
      if (int_ready_reg) begin
        if (m_axis_tready || !m_axis_tvalid) begin
          m_axis_tvalid <= xfer;
          if (xfer) begin
            m_axis_tdata <= sel_data;
            m_axis_tkeep <= sel_keep;
            m_axis_tlast <= sel_last;
            m_axis_tid   <= grant_index;
            m_axis_tuser <= sel_user;
          end
        end else begin
          temp_valid <= xfer;
          if (xfer) begin
            temp_data <= sel_data;
            temp_keep <= sel_keep;
            temp_last <= sel_last;
            temp_tid  <= grant_index;
            temp_user <= sel_user;
          end
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= temp_valid;
        m_axis_tdata  <= temp_data;
        m_axis_tkeep  <= temp_keep;
        m_axis_tlast  <= temp_last;
        m_axis_tid    <= temp_tid;
        m_axis_tuser  <= temp_user;
        temp_valid    <= 1'b0;
      end
    end
  end

endmodule
